// File: rtl/vote_pkg.sv
// Shared definitions for the vote tally unit: FSM states, winner codes and
// the fixed ordering of the four vote lines.
package vote_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DECIDE  = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [1:0] W_PS = 2'd0;
    localparam logic [1:0] W_PC = 2'd1;
    localparam logic [1:0] W_D  = 2'd2;
    localparam logic [1:0] W_B  = 2'd3;

    // Line index equals winner code, so the lowest index wins ties.
    localparam int N_LINES = 4;
    localparam int IDX_PS  = 0;
    localparam int IDX_PC  = 1;
    localparam int IDX_D   = 2;
    localparam int IDX_B   = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat_hit flags an increment
// that was dropped because the count was already all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat_hit
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max  = &count_q;
    assign sat_hit = inc && at_max;
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Ballot tally: counts the four vote lines, blanks and total while collecting,
// then on close picks a winner/tie and holds the result until clear.
module vote_tally
    import vote_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             volps,
    input  logic             volpc,
    input  logic             vold,
    input  logic             volb,
    input  logic             close,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt_ps,
    output logic [CNT_W-1:0] cnt_pc,
    output logic [CNT_W-1:0] cnt_d,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_blank,
    output logic [CNT_W+1:0] total,
    output logic             result_valid,
    output logic [1:0]       winner,
    output logic             tie,
    output logic             overflow
);

    state_t               state_q;
    logic [1:0]           winner_q;
    logic                 tie_q;
    logic                 rv_q;
    logic                 ovf_q;
    logic                 ovf_d;

    logic                 accept;
    logic [N_LINES-1:0]   lines;
    logic [N_LINES-1:0]   line_inc;
    logic [CNT_W-1:0]     line_cnt [N_LINES];
    logic [N_LINES+1:0]   sat_hits;

    logic [CNT_W-1:0]     max_c;
    logic [1:0]           win_c;
    logic [2:0]           holders_c;
    logic                 tie_c;

    assign in_ready = (state_q == COLLECT);
    // A clear in the same cycle drops the ballot.
    assign accept   = in_valid && in_ready && !clear;

    always_comb begin
        lines         = '0;
        lines[IDX_PS] = volps;
        lines[IDX_PC] = volpc;
        lines[IDX_D]  = vold;
        lines[IDX_B]  = volb;
    end

    assign line_inc = accept ? lines : '0;

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        sat_counter #(.WIDTH(CNT_W)) u_line (
            .clk     (clk),
            .rst     (rst),
            .inc     (line_inc[g]),
            .clr     (clear),
            .count   (line_cnt[g]),
            .sat_hit (sat_hits[g])
        );
    end

    sat_counter #(.WIDTH(CNT_W)) u_blank (
        .clk     (clk),
        .rst     (rst),
        .inc     (accept && (lines == '0)),
        .clr     (clear),
        .count   (cnt_blank),
        .sat_hit (sat_hits[N_LINES])
    );

    sat_counter #(.WIDTH(CNT_W + 2)) u_total (
        .clk     (clk),
        .rst     (rst),
        .inc     (accept),
        .clr     (clear),
        .count   (total),
        .sat_hit (sat_hits[N_LINES+1])
    );

    assign cnt_ps = line_cnt[IDX_PS];
    assign cnt_pc = line_cnt[IDX_PC];
    assign cnt_d  = line_cnt[IDX_D];
    assign cnt_b  = line_cnt[IDX_B];

    // Strict '>' keeps the lowest index when several lines share the maximum.
    always_comb begin
        max_c     = line_cnt[0];
        win_c     = W_PS;
        holders_c = '0;
        for (int i = 1; i < N_LINES; i++) begin
            if (line_cnt[i] > max_c) begin
                max_c = line_cnt[i];
                win_c = 2'(i);
            end
        end
        for (int i = 0; i < N_LINES; i++) begin
            if (line_cnt[i] == max_c) begin
                holders_c = holders_c + 3'd1;
            end
        end
        tie_c = (holders_c > 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLLECT;
            winner_q <= W_PS;
            tie_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else if (clear) begin
            state_q  <= COLLECT;
            winner_q <= W_PS;
            tie_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (close) begin
                        state_q <= DECIDE;
                    end
                end
                DECIDE: begin
                    winner_q <= win_c;
                    tie_q    <= tie_c;
                    rv_q     <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign ovf_d = clear ? 1'b0 : (ovf_q || (|sat_hits));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign result_valid = rv_q;
    assign winner       = winner_q;
    assign tie          = tie_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_vote_tally.sv
// Randomized scoreboard bench for vote_tally, run at CNT_W=8 and CNT_W=2 side by side.
module tb_vote_tally;

    localparam int W8 = 8;
    localparam int W2 = 2;

    typedef struct packed {
        logic [3:0][15:0] c;
        logic [15:0]      blank;
        logic [15:0]      total;
        logic             ov;
        logic             rv;
        logic [1:0]       win;
        logic             tie;
        logic             rdy;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic volps = 1'b0, volpc = 1'b0, vold = 1'b0, volb = 1'b0;
    logic close = 1'b0, clear = 1'b0;

    logic          rdy8, rv8, tie8, ov8;
    logic [1:0]    win8;
    logic [W8-1:0] ps8, pc8, d8, b8, bl8;
    logic [W8+1:0] tot8;

    logic          rdy2, rv2, tie2, ov2;
    logic [1:0]    win2;
    logic [W2-1:0] ps2, pc2, d2, b2, bl2;
    logic [W2+1:0] tot2;

    int n_cmp = 0;
    int n_bad = 0;

    snap_t q8[$];
    snap_t q2[$];
    snap_t m8, m2;
    bit    collecting;
    bit    deciding;

    always #5 clk = ~clk;

    vote_tally #(.CNT_W(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .volps(volps), .volpc(volpc), .vold(vold), .volb(volb),
        .close(close), .clear(clear),
        .cnt_ps(ps8), .cnt_pc(pc8), .cnt_d(d8), .cnt_b(b8), .cnt_blank(bl8),
        .total(tot8), .result_valid(rv8), .winner(win8), .tie(tie8), .overflow(ov8)
    );

    vote_tally #(.CNT_W(W2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .volps(volps), .volpc(volpc), .vold(vold), .volb(volb),
        .close(close), .clear(clear),
        .cnt_ps(ps2), .cnt_pc(pc2), .cnt_d(d2), .cnt_b(b2), .cnt_blank(bl2),
        .total(tot2), .result_valid(rv2), .winner(win2), .tie(tie2), .overflow(ov2)
    );

    function automatic snap_t reset_snap();
        snap_t s;
        s     = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    // Reference model: plain per-line counts with saturation at cmax/tmax.
    function automatic snap_t step(snap_t s, bit iv, logic [3:0] ln, bit cl_in_collect,
                                   bit clr, bit coll, bit dec, int cmax, int tmax);
        snap_t       n;
        logic [15:0] mx;
        int          holders;
        bit          found;
        n = s;
        if (clr) return reset_snap();
        if (coll) begin
            if (iv) begin
                for (int i = 0; i < 4; i++) begin
                    if (ln[i]) begin
                        if (s.c[i] == 16'(cmax)) n.ov = 1'b1;
                        else n.c[i] = s.c[i] + 16'd1;
                    end
                end
                if (ln == 4'd0) begin
                    if (s.blank == 16'(cmax)) n.ov = 1'b1;
                    else n.blank = s.blank + 16'd1;
                end
                if (s.total == 16'(tmax)) n.ov = 1'b1;
                else n.total = s.total + 16'd1;
            end
        end else if (dec) begin
            mx = s.c[0];
            for (int i = 1; i < 4; i++) if (s.c[i] > mx) mx = s.c[i];
            holders = 0;
            found   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (s.c[i] == mx) begin
                    holders++;
                    if (!found) begin
                        n.win = 2'(i);
                        found = 1'b1;
                    end
                end
            end
            n.tie = (holders > 1);
            n.rv  = 1'b1;
        end
        if (cl_in_collect) n.rdy = 1'b0;
        return n;
    endfunction

    function automatic snap_t act8();
        snap_t a;
        a = '0;
        a.c[0] = 16'(ps8); a.c[1] = 16'(pc8); a.c[2] = 16'(d8); a.c[3] = 16'(b8);
        a.blank = 16'(bl8); a.total = 16'(tot8);
        a.ov = ov8; a.rv = rv8; a.win = win8; a.tie = tie8; a.rdy = rdy8;
        return a;
    endfunction

    function automatic snap_t act2();
        snap_t a;
        a = '0;
        a.c[0] = 16'(ps2); a.c[1] = 16'(pc2); a.c[2] = 16'(d2); a.c[3] = 16'(b2);
        a.blank = 16'(bl2); a.total = 16'(tot2);
        a.ov = ov2; a.rv = rv2; a.win = win2; a.tie = tie2; a.rdy = rdy2;
        return a;
    endfunction

    task automatic compare(input string name, input snap_t a, input snap_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got ps=%0d pc=%0d d=%0d b=%0d blank=%0d total=%0d ov=%0b rv=%0b win=%0d tie=%0b rdy=%0b | want ps=%0d pc=%0d d=%0d b=%0d blank=%0d total=%0d ov=%0b rv=%0b win=%0d tie=%0b rdy=%0b",
                     name, $time, a.c[0], a.c[1], a.c[2], a.c[3], a.blank, a.total, a.ov, a.rv, a.win, a.tie, a.rdy,
                     e.c[0], e.c[1], e.c[2], e.c[3], e.blank, e.total, e.ov, e.rv, e.win, e.tie, e.rdy);
        end
    endtask

    task automatic cyc(input bit iv, input logic [3:0] ln, input bit cl, input bit clr);
        bit cl_eff;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = iv;
        volps    = ln[0];
        volpc    = ln[1];
        vold     = ln[2];
        volb     = ln[3];
        close    = cl;
        clear    = clr;
        cl_eff   = cl && collecting && !clr;
        m8 = step(m8, iv, ln, cl_eff, clr, collecting, deciding, (1 << W8) - 1, (1 << (W8 + 2)) - 1);
        m2 = step(m2, iv, ln, cl_eff, clr, collecting, deciding, (1 << W2) - 1, (1 << (W2 + 2)) - 1);
        if (clr) begin
            collecting = 1'b1;
            deciding   = 1'b0;
        end else if (cl_eff) begin
            collecting = 1'b0;
            deciding   = 1'b1;
        end else begin
            deciding = 1'b0;
        end
        q8.push_back(m8);
        q2.push_back(m2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0;
        close    = 1'b0;
        clear    = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        compare("async_rst_w8", act8(), reset_snap());
        compare("async_rst_w2", act2(), reset_snap());
        m8 = reset_snap();
        m2 = reset_snap();
        collecting = 1'b1;
        deciding   = 1'b0;
        q8.push_back(m8);
        q2.push_back(m2);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() == 0 || q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underrun t=%0t got empty queue want one entry", $time);
            end else begin
                compare("cycle_w8", act8(), q8.pop_front());
                compare("cycle_w2", act2(), q2.pop_front());
            end
        end
    end

    initial begin : stimulus
        m8         = reset_snap();
        m2         = reset_snap();
        collecting = 1'b1;
        deciding   = 1'b0;
        q8.push_back(m8);
        q2.push_back(m2);

        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 4'b0010, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        idle(3);

        cyc(1'b0, 4'b0000, 1'b0, 1'b1);
        cyc(1'b1, 4'b1100, 1'b0, 1'b0);
        cyc(1'b1, 4'b1100, 1'b0, 1'b0);
        cyc(1'b1, 4'b1000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        idle(2);
        cyc(1'b1, 4'b1111, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b1, 1'b0);
        idle(1);

        cyc(1'b0, 4'b0000, 1'b0, 1'b1);
        cyc(1'b1, 4'b0001, 1'b0, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0, 1'b0);
        cyc(1'b1, 4'b0100, 1'b1, 1'b0);
        idle(3);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        idle(3);

        cyc(1'b0, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 300; i++) cyc(1'b1, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);
        idle(3);
        cyc(1'b1, 4'b0001, 1'b1, 1'b1);
        idle(1);
        cyc(1'b1, 4'b0011, 1'b0, 1'b0);
        cyc(1'b1, 4'b0011, 1'b1, 1'b1);
        idle(1);

        cyc(1'b1, 4'b0101, 1'b0, 1'b0);
        cyc(1'b1, 4'b1010, 1'b0, 1'b0);
        async_reset();
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
        end
        idle(2);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
